can_tx_queue: RTL and testbench

//  Frame-level transmit queue directly upstream of the mcp2515 SPI driver.

---
 rtl/can_tx_queue_if.sv | 30 +++
 rtl/can_tx_queue.sv | 138 +++++++++++++
 tb/tb_can_tx_queue.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/can_tx_queue_if.sv
// Bundle between user push logic, the CAN transmit queue and the mcp2515 driver.
// master = user/driver side, slave = the queue.
interface can_tx_queue_if #(
    parameter int unsigned ADDR_W = 3
);
    logic              wr_en;
    logic [10:0]       wr_id;
    logic [3:0]        wr_dlc;
    logic [63:0]       wr_data;
    logic              wr_full;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              tx_empty;
    logic              frm_valid;
    logic [10:0]       frm_id;
    logic [3:0]        frm_dlc;
    logic [63:0]       frm_data;
    logic              frm_ack;
    logic              tmo;

    modport master (
        output wr_en, wr_id, wr_dlc, wr_data, tx_empty, frm_ack,
        input  wr_full, count, overflow, frm_valid, frm_id, frm_dlc, frm_data, tmo
    );

    modport slave (
        input  wr_en, wr_id, wr_dlc, wr_data, tx_empty, frm_ack,
        output wr_full, count, overflow, frm_valid, frm_id, frm_dlc, frm_data, tmo
    );
endinterface

// File: rtl/can_tx_queue.sv
// Frame FIFO feeding the mcp2515 driver one frame at a time, paced on tx_empty so
// TXB0 is only written once the previous frame has been picked up by the controller.
module can_tx_queue #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned ADDR_W  = 3,
    parameter int unsigned TMO_CYC = 50000,
    parameter int unsigned TMO_W   = 16
) (
    input logic           clk50,
    input logic           rst,
    can_tx_queue_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StPresent, StWaitBusy} state_e;

    localparam logic [ADDR_W:0]   FullCnt = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CntOne  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PtrOne  = ADDR_W'(1);
    localparam logic [TMO_W-1:0]  TmoLast = TMO_W'(TMO_CYC - 1);
    localparam logic [TMO_W-1:0]  TmoOne  = TMO_W'(1);

    // Slot layout: {id[10:0], dlc[3:0], data[63:0]}
    logic [78:0]       mem_q [DEPTH];

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [ADDR_W:0]   count_q, count_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic              frm_valid_q;
    logic [10:0]       frm_id_q;
    logic [3:0]        frm_dlc_q;
    logic [63:0]       frm_data_q;
    logic              overflow_q;
    logic              tmo_q;

    logic              pop, push, load, tmo_hit;
    logic [3:0]        dlc_clamped;
    logic [78:0]       head;

    assign pop         = (state_q == StPresent) && bus.frm_ack;
    // A full queue still accepts a push when the head leaves on the same edge.
    assign push        = bus.wr_en && ((count_q != FullCnt) || pop);
    assign dlc_clamped = (bus.wr_dlc > 4'd8) ? 4'd8 : bus.wr_dlc;
    assign head        = mem_q[rd_ptr_q];

    always_comb begin
        state_d   = state_q;
        tmo_cnt_d = tmo_cnt_q;
        load      = 1'b0;
        tmo_hit   = 1'b0;
        case (state_q)
            StIdle: begin
                if ((count_q != '0) && bus.tx_empty) begin
                    load    = 1'b1;
                    state_d = StPresent;
                end
            end
            StPresent: begin
                if (bus.frm_ack) begin
                    tmo_cnt_d = '0;
                    state_d   = StWaitBusy;
                end
            end
            StWaitBusy: begin
                if (!bus.tx_empty) begin
                    state_d = StIdle;
                end else if (tmo_cnt_q == TmoLast) begin
                    tmo_hit = 1'b1;
                    state_d = StIdle;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TmoOne;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk50) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.wr_id, dlc_clamped, bus.wr_data};
        end
    end

    always_ff @(posedge clk50) begin
        if (rst) begin
            state_q     <= StIdle;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            tmo_cnt_q   <= '0;
            frm_valid_q <= 1'b0;
            frm_id_q    <= '0;
            frm_dlc_q   <= '0;
            frm_data_q  <= '0;
            overflow_q  <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            tmo_cnt_q <= tmo_cnt_d;
            tmo_q     <= tmo_hit;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
            end
            if (bus.wr_en && !push) begin
                overflow_q <= 1'b1;
            end
            if (load) begin
                frm_valid_q <= 1'b1;
                frm_id_q    <= head[78:68];
                frm_dlc_q   <= head[67:64];
                frm_data_q  <= head[63:0];
            end else if (pop) begin
                frm_valid_q <= 1'b0;
            end
        end
    end

    assign bus.wr_full   = (count_q == FullCnt);
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.frm_valid = frm_valid_q;
    assign bus.frm_id    = frm_id_q;
    assign bus.frm_dlc   = frm_dlc_q;
    assign bus.frm_data  = frm_data_q;
    assign bus.tmo       = tmo_q;
endmodule

// File: tb/tb_can_tx_queue.sv
// Directed bench for can_tx_queue: a vector table for single-frame flows plus
// hand-written sequences for ordering, overflow, reset and timeout.
module tb_can_tx_queue;
    localparam int unsigned DEPTH   = 8;
    localparam int unsigned ADDR_W  = 3;
    localparam int unsigned TMO_CYC = 20;
    localparam int unsigned TMO_W   = 5;
    localparam int NVEC = 17;

    localparam logic [63:0] D1 = 64'hAABB_0000_0000_0000;
    localparam logic [63:0] D2 = 64'h0102_0304_0506_0708;
    localparam logic [63:0] D3 = 64'h1100_0000_0000_0000;

    typedef struct {
        logic        rst;
        logic        we;
        logic [10:0] id;
        logic [3:0]  dlc;
        logic [63:0] data;
        logic        te;
        logic        ack;
        logic        ev;
        logic [10:0] eid;
        logic [3:0]  edlc;
        logic [63:0] edata;
        logic [3:0]  ecnt;
        logic        efull;
        logic        eovf;
        logic        etmo;
    } vec_t;

    logic clk50;
    logic rst;
    int   checks;
    int   errors;
    vec_t vecs [NVEC];

    can_tx_queue_if #(.ADDR_W(ADDR_W)) bus ();

    can_tx_queue #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .TMO_CYC(TMO_CYC),
        .TMO_W  (TMO_W)
    ) dut (
        .clk50(clk50),
        .rst  (rst),
        .bus  (bus)
    );

    initial begin
        clk50 = 1'b0;
        forever #10 clk50 = ~clk50;
    end

    function automatic vec_t mk(input logic r, input logic we, input logic [10:0] id,
                                input logic [3:0] dlc, input logic [63:0] data,
                                input logic te, input logic ack, input logic ev,
                                input logic [10:0] eid, input logic [3:0] edlc,
                                input logic [63:0] edata, input logic [3:0] ecnt,
                                input logic efull, input logic eovf, input logic etmo);
        vec_t v;
        v.rst = r; v.we = we; v.id = id; v.dlc = dlc; v.data = data; v.te = te;
        v.ack = ack; v.ev = ev; v.eid = eid; v.edlc = edlc; v.edata = edata;
        v.ecnt = ecnt; v.efull = efull; v.eovf = eovf; v.etmo = etmo;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk50);
        #1;
    endtask

    task automatic push(input logic [10:0] id, input logic [3:0] dlc, input logic [63:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_id   = id;
        bus.wr_dlc  = dlc;
        bus.wr_data = data;
        step();
        bus.wr_en = 1'b0;
    endtask

    initial begin
        logic [10:0] exp_ids [8];
        logic        seen_valid;
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.wr_en = 1'b0;
        bus.wr_id = '0;
        bus.wr_dlc = '0;
        bus.wr_data = '0;
        bus.tx_empty = 1'b0;
        bus.frm_ack = 1'b0;

        //          rst we  id      dlc    data   te  ack  v   id      dlc   data cnt f  o  t
        vecs[0]  = mk(1, 0, 11'h000, 4'd0,  '0, 0, 0,   0, 11'h000, 4'd0, '0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 1, 11'h123, 4'd2,  D1, 1, 0,   0, 11'h000, 4'd0, '0, 1, 0, 0, 0);
        vecs[2]  = mk(0, 0, 11'h000, 4'd0,  '0, 1, 0,   1, 11'h123, 4'd2, D1, 1, 0, 0, 0);
        vecs[3]  = mk(0, 0, 11'h000, 4'd0,  '0, 1, 1,   0, 11'h123, 4'd2, D1, 0, 0, 0, 0);
        vecs[4]  = mk(0, 0, 11'h000, 4'd0,  '0, 0, 0,   0, 11'h123, 4'd2, D1, 0, 0, 0, 0);
        vecs[5]  = mk(0, 1, 11'h7FF, 4'd15, D2, 0, 0,   0, 11'h123, 4'd2, D1, 1, 0, 0, 0);
        vecs[6]  = mk(0, 1, 11'h001, 4'd0,  '0, 1, 0,   1, 11'h7FF, 4'd8, D2, 2, 0, 0, 0);
        vecs[7]  = mk(0, 0, 11'h000, 4'd0,  '0, 1, 1,   0, 11'h7FF, 4'd8, D2, 1, 0, 0, 0);
        vecs[8]  = mk(0, 0, 11'h000, 4'd0,  '0, 0, 0,   0, 11'h7FF, 4'd8, D2, 1, 0, 0, 0);
        vecs[9]  = mk(0, 0, 11'h000, 4'd0,  '0, 1, 0,   1, 11'h001, 4'd0, '0, 1, 0, 0, 0);
        vecs[10] = mk(0, 0, 11'h000, 4'd0,  '0, 1, 1,   0, 11'h001, 4'd0, '0, 0, 0, 0, 0);
        vecs[11] = mk(0, 0, 11'h000, 4'd0,  '0, 0, 0,   0, 11'h001, 4'd0, '0, 0, 0, 0, 0);
        vecs[12] = mk(0, 1, 11'h055, 4'd1,  D3, 0, 1,   0, 11'h001, 4'd0, '0, 1, 0, 0, 0);
        vecs[13] = mk(0, 0, 11'h000, 4'd0,  '0, 0, 1,   0, 11'h001, 4'd0, '0, 1, 0, 0, 0);
        vecs[14] = mk(0, 0, 11'h000, 4'd0,  '0, 1, 0,   1, 11'h055, 4'd1, D3, 1, 0, 0, 0);
        vecs[15] = mk(0, 0, 11'h000, 4'd0,  '0, 1, 1,   0, 11'h055, 4'd1, D3, 0, 0, 0, 0);
        vecs[16] = mk(0, 0, 11'h000, 4'd0,  '0, 0, 0,   0, 11'h055, 4'd1, D3, 0, 0, 0, 0);

        for (int i = 0; i < NVEC; i++) begin
            rst          = vecs[i].rst;
            bus.wr_en    = vecs[i].we;
            bus.wr_id    = vecs[i].id;
            bus.wr_dlc   = vecs[i].dlc;
            bus.wr_data  = vecs[i].data;
            bus.tx_empty = vecs[i].te;
            bus.frm_ack  = vecs[i].ack;
            step();
            chk($sformatf("v%0d frm_valid", i), 64'(bus.frm_valid), 64'(vecs[i].ev));
            chk($sformatf("v%0d frm_id", i),    64'(bus.frm_id),    64'(vecs[i].eid));
            chk($sformatf("v%0d frm_dlc", i),   64'(bus.frm_dlc),   64'(vecs[i].edlc));
            chk($sformatf("v%0d frm_data", i),  bus.frm_data,       vecs[i].edata);
            chk($sformatf("v%0d count", i),     64'(bus.count),     64'(vecs[i].ecnt));
            chk($sformatf("v%0d wr_full", i),   64'(bus.wr_full),   64'(vecs[i].efull));
            chk($sformatf("v%0d overflow", i),  64'(bus.overflow),  64'(vecs[i].eovf));
            chk($sformatf("v%0d tmo", i),       64'(bus.tmo),       64'(vecs[i].etmo));
        end
        rst = 1'b0; bus.wr_en = 1'b0; bus.tx_empty = 1'b0; bus.frm_ack = 1'b0;

        // FIFO order with tx_empty held low while pushing
        for (int i = 0; i < 3; i++) push(11'h100 + 11'(i), 4'd3, 64'(i));
        chk("order count", 64'(bus.count), 64'd3);
        chk("order no valid", 64'(bus.frm_valid), 64'd0);
        for (int k = 0; k < 3; k++) begin
            bus.tx_empty = 1'b1;
            step();
            chk($sformatf("order%0d valid", k), 64'(bus.frm_valid), 64'd1);
            chk($sformatf("order%0d id", k), 64'(bus.frm_id), 64'(11'h100 + 11'(k)));
            bus.frm_ack = 1'b1;
            step();
            bus.frm_ack = 1'b0;
            chk($sformatf("order%0d ack clears", k), 64'(bus.frm_valid), 64'd0);
            bus.tx_empty = 1'b0;
            step();
        end

        // Fill, overflow, then push and pop on the same edge while full
        for (int i = 0; i < 9; i++) begin
            push(11'h200 + 11'(i), 4'd1, 64'(i));
            if (i == 7) begin
                chk("full count", 64'(bus.count), 64'd8);
                chk("full flag", 64'(bus.wr_full), 64'd1);
                chk("full no ovf yet", 64'(bus.overflow), 64'd0);
            end
        end
        chk("ovf count", 64'(bus.count), 64'd8);
        chk("ovf flag", 64'(bus.overflow), 64'd1);
        bus.tx_empty = 1'b1;
        step();
        chk("full head id", 64'(bus.frm_id), 64'h200);
        bus.frm_ack = 1'b1;
        push(11'h2AA, 4'd2, 64'hDEAD);
        bus.frm_ack = 1'b0;
        chk("push+pop count", 64'(bus.count), 64'd8);
        chk("push+pop ovf sticky", 64'(bus.overflow), 64'd1);
        for (int j = 0; j < 7; j++) exp_ids[j] = 11'h201 + 11'(j);
        exp_ids[7] = 11'h2AA;
        for (int j = 0; j < 8; j++) begin
            bus.tx_empty = 1'b0;
            step();
            bus.tx_empty = 1'b1;
            step();
            chk($sformatf("drain%0d id", j), 64'(bus.frm_id), 64'(exp_ids[j]));
            bus.frm_ack = 1'b1;
            step();
            bus.frm_ack = 1'b0;
        end
        bus.tx_empty = 1'b0;
        step();
        chk("drain count", 64'(bus.count), 64'd0);

        // Reset while presenting with frames still queued
        for (int i = 0; i < 5; i++) push(11'h300 + 11'(i), 4'd4, 64'(i));
        bus.tx_empty = 1'b1;
        step();
        chk("pre-rst valid", 64'(bus.frm_valid), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst valid", 64'(bus.frm_valid), 64'd0);
        chk("rst count", 64'(bus.count), 64'd0);
        chk("rst overflow", 64'(bus.overflow), 64'd0);
        chk("rst frm_id", 64'(bus.frm_id), 64'd0);
        seen_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.frm_valid) seen_valid = 1'b1;
        end
        chk("post-rst no frame", 64'(seen_valid), 64'd0);

        // Timeout in WAIT_BUSY with tx_empty stuck high
        bus.tx_empty = 1'b0;
        push(11'h400, 4'd1, 64'h1);
        push(11'h401, 4'd1, 64'h2);
        bus.tx_empty = 1'b1;
        step();
        chk("tmo first id", 64'(bus.frm_id), 64'h400);
        bus.frm_ack = 1'b1;
        step();
        bus.frm_ack = 1'b0;
        for (int k = 1; k <= int'(TMO_CYC) + 1; k++) begin
            step();
            chk($sformatf("tmo c%0d", k), 64'(bus.tmo), 64'(k == int'(TMO_CYC)));
            if (k <= int'(TMO_CYC)) begin
                chk($sformatf("tmo c%0d valid", k), 64'(bus.frm_valid), 64'd0);
            end else begin
                chk("tmo next valid", 64'(bus.frm_valid), 64'd1);
                chk("tmo next id", 64'(bus.frm_id), 64'h401);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
